// File: rtl/ip_tx_resolve.sv
// Resolves the destination MAC of an outgoing IP header through a one-entry cache or an ARP
// lookup, then forwards, drops (on failure) or skips (probe mode) the matching payload.
module ip_tx_resolve #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ARP_TIMEOUT  = 1024,
    parameter int unsigned CACHE_ENABLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s_ip_hdr_valid,
    output logic                  s_ip_hdr_ready,
    input  logic [31:0]           s_ip_dest_ip,
    input  logic [DATA_WIDTH-1:0] s_ip_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_ip_payload_axis_tkeep,
    input  logic                  s_ip_payload_axis_tvalid,
    output logic                  s_ip_payload_axis_tready,
    input  logic                  s_ip_payload_axis_tlast,
    input  logic                  s_ip_payload_axis_tuser,

    output logic                  m_ip_hdr_valid,
    input  logic                  m_ip_hdr_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [DATA_WIDTH-1:0] m_ip_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_ip_payload_axis_tkeep,
    output logic                  m_ip_payload_axis_tvalid,
    input  logic                  m_ip_payload_axis_tready,
    output logic                  m_ip_payload_axis_tlast,
    output logic                  m_ip_payload_axis_tuser,

    output logic                  arp_request_valid,
    input  logic                  arp_request_ready,
    output logic [31:0]           arp_request_ip,
    input  logic                  arp_response_valid,
    output logic                  arp_response_ready,
    input  logic                  arp_response_error,
    input  logic [47:0]           arp_response_mac,

    input  logic                  probe_only,
    input  logic                  cache_invalidate,
    output logic                  drop_packet,
    output logic                  skip_packet,
    output logic                  error_arp_failed,
    output logic                  error_arp_timeout,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StArpQuery, StWaitPacket} state_t;

    localparam logic [23:0] TIMER_LAST = 24'(ARP_TIMEOUT - 1);

    state_t      r_state;
    logic        r_hdr_ready;
    logic        r_m_hdr_valid;
    logic        r_arp_req_valid;
    logic        r_arp_resp_ready;
    logic        r_drop;
    logic        r_skip;
    logic        r_err_failed;
    logic        r_err_timeout;
    logic        r_busy;
    logic        r_probe;
    logic [23:0] r_timer;
    logic [47:0] r_dest_mac;

    logic        w_cache_hit;
    logic [47:0] w_cache_mac;
    logic        w_in_wait;
    logic        w_discard;
    logic        w_beat;
    logic        w_resp;
    logic        w_timeout;
    logic        w_cache_load;

    assign w_in_wait    = (r_state == StWaitPacket);
    assign w_discard    = r_drop | r_skip;
    assign w_beat       = s_ip_payload_axis_tvalid & s_ip_payload_axis_tready;
    assign w_resp       = (r_state == StArpQuery) & arp_response_valid;
    // A response in the final timeout cycle wins over the timeout.
    assign w_timeout    = (r_state == StArpQuery) & ~arp_response_valid & (r_timer == TIMER_LAST);
    assign w_cache_load = w_resp & ~arp_response_error;

    assign s_ip_payload_axis_tready = w_in_wait & (w_discard | m_ip_payload_axis_tready);
    assign m_ip_payload_axis_tvalid = w_in_wait & ~w_discard & s_ip_payload_axis_tvalid;
    assign m_ip_payload_axis_tdata  = s_ip_payload_axis_tdata;
    assign m_ip_payload_axis_tkeep  = s_ip_payload_axis_tkeep;
    assign m_ip_payload_axis_tlast  = s_ip_payload_axis_tlast;
    assign m_ip_payload_axis_tuser  = s_ip_payload_axis_tuser;

    assign s_ip_hdr_ready     = r_hdr_ready;
    assign m_ip_hdr_valid     = r_m_hdr_valid;
    assign m_eth_dest_mac     = r_dest_mac;
    assign arp_request_valid  = r_arp_req_valid;
    assign arp_request_ip     = s_ip_dest_ip;
    assign arp_response_ready = r_arp_resp_ready;
    assign drop_packet        = r_drop;
    assign skip_packet        = r_skip;
    assign error_arp_failed   = r_err_failed;
    assign error_arp_timeout  = r_err_timeout;
    assign busy               = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= StIdle;
            r_hdr_ready      <= 1'b0;
            r_m_hdr_valid    <= 1'b0;
            r_arp_req_valid  <= 1'b0;
            r_arp_resp_ready <= 1'b0;
            r_drop           <= 1'b0;
            r_skip           <= 1'b0;
            r_err_failed     <= 1'b0;
            r_err_timeout    <= 1'b0;
            r_busy           <= 1'b0;
            r_probe          <= 1'b0;
            r_timer          <= '0;
        end else begin
            r_hdr_ready   <= 1'b0;
            r_err_failed  <= 1'b0;
            r_err_timeout <= 1'b0;
            if (r_m_hdr_valid && m_ip_hdr_ready) begin
                r_m_hdr_valid <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    if (s_ip_hdr_valid) begin
                        r_busy  <= 1'b1;
                        r_probe <= probe_only;
                        if (w_cache_hit) begin
                            r_hdr_ready   <= 1'b1;
                            r_m_hdr_valid <= 1'b1;
                            r_dest_mac    <= w_cache_mac;
                            r_state       <= StWaitPacket;
                        end else begin
                            r_arp_req_valid  <= 1'b1;
                            r_arp_resp_ready <= 1'b1;
                            r_timer          <= '0;
                            r_state          <= StArpQuery;
                        end
                    end
                end
                StArpQuery: begin
                    r_timer <= r_timer + 24'd1;
                    if (r_arp_req_valid && arp_request_ready) begin
                        r_arp_req_valid <= 1'b0;
                    end
                    if (w_resp) begin
                        r_hdr_ready      <= 1'b1;
                        r_arp_req_valid  <= 1'b0;
                        r_arp_resp_ready <= 1'b0;
                        r_state          <= StWaitPacket;
                        if (arp_response_error) begin
                            r_err_failed <= 1'b1;
                            r_drop       <= 1'b1;
                        end else begin
                            r_dest_mac <= arp_response_mac;
                            if (r_probe) begin
                                r_skip <= 1'b1;
                            end else begin
                                r_m_hdr_valid <= 1'b1;
                            end
                        end
                    end else if (w_timeout) begin
                        r_hdr_ready      <= 1'b1;
                        r_err_timeout    <= 1'b1;
                        r_arp_req_valid  <= 1'b0;
                        r_arp_resp_ready <= 1'b0;
                        r_drop           <= 1'b1;
                        r_state          <= StWaitPacket;
                    end
                end
                StWaitPacket: begin
                    if (w_beat && s_ip_payload_axis_tlast) begin
                        r_drop  <= 1'b0;
                        r_skip  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    if (CACHE_ENABLE != 0) begin : g_cache
        logic        r_cache_valid;
        logic [31:0] r_cache_ip;
        logic [47:0] r_cache_mac;
        logic        w_ip_match;
        logic        w_cache_clear;

        assign w_ip_match    = (r_cache_ip == s_ip_dest_ip);
        assign w_cache_clear = cache_invalidate | (w_resp & arp_response_error & w_ip_match);
        assign w_cache_hit   = r_cache_valid & w_ip_match & ~probe_only;
        assign w_cache_mac   = r_cache_mac;

        // Invalidation outranks a simultaneous load.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cache_valid <= 1'b0;
            end else if (w_cache_clear) begin
                r_cache_valid <= 1'b0;
            end else if (w_cache_load) begin
                r_cache_valid <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_cache_load) begin
                r_cache_ip  <= s_ip_dest_ip;
                r_cache_mac <= arp_response_mac;
            end
        end
    end else begin : g_no_cache
        assign w_cache_hit = 1'b0;
        assign w_cache_mac = '0;
    end

endmodule

// File: tb/tb_ip_tx_resolve.sv
// Bench for ip_tx_resolve: directed scenarios plus randomized packets scored against a
// behavioural cache/outcome model.
module tb_ip_tx_resolve;

    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int TMO = 16;

    typedef logic [DW+KW+1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_ip_hdr_valid, s_ip_hdr_ready;
    logic [31:0]   s_ip_dest_ip;
    logic [DW-1:0] s_tdata, m_tdata;
    logic [KW-1:0] s_tkeep, m_tkeep;
    logic          s_tvalid, s_tready, s_tlast, s_tuser;
    logic          m_tvalid, m_tready, m_tlast, m_tuser;
    logic          m_ip_hdr_valid, m_ip_hdr_ready;
    logic [47:0]   m_eth_dest_mac;
    logic          arp_request_valid, arp_request_ready;
    logic [31:0]   arp_request_ip;
    logic          arp_response_valid, arp_response_ready, arp_response_error;
    logic [47:0]   arp_response_mac;
    logic          probe_only, cache_invalidate;
    logic          drop_packet, skip_packet, error_arp_failed, error_arp_timeout, busy;

    always #5 clk = ~clk;

    ip_tx_resolve #(
        .DATA_WIDTH  (DW),
        .KEEP_WIDTH  (KW),
        .ARP_TIMEOUT (TMO),
        .CACHE_ENABLE(1)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .s_ip_hdr_valid          (s_ip_hdr_valid),
        .s_ip_hdr_ready          (s_ip_hdr_ready),
        .s_ip_dest_ip            (s_ip_dest_ip),
        .s_ip_payload_axis_tdata (s_tdata),
        .s_ip_payload_axis_tkeep (s_tkeep),
        .s_ip_payload_axis_tvalid(s_tvalid),
        .s_ip_payload_axis_tready(s_tready),
        .s_ip_payload_axis_tlast (s_tlast),
        .s_ip_payload_axis_tuser (s_tuser),
        .m_ip_hdr_valid          (m_ip_hdr_valid),
        .m_ip_hdr_ready          (m_ip_hdr_ready),
        .m_eth_dest_mac          (m_eth_dest_mac),
        .m_ip_payload_axis_tdata (m_tdata),
        .m_ip_payload_axis_tkeep (m_tkeep),
        .m_ip_payload_axis_tvalid(m_tvalid),
        .m_ip_payload_axis_tready(m_tready),
        .m_ip_payload_axis_tlast (m_tlast),
        .m_ip_payload_axis_tuser (m_tuser),
        .arp_request_valid       (arp_request_valid),
        .arp_request_ready       (arp_request_ready),
        .arp_request_ip          (arp_request_ip),
        .arp_response_valid      (arp_response_valid),
        .arp_response_ready      (arp_response_ready),
        .arp_response_error      (arp_response_error),
        .arp_response_mac        (arp_response_mac),
        .probe_only              (probe_only),
        .cache_invalidate        (cache_invalidate),
        .drop_packet             (drop_packet),
        .skip_packet             (skip_packet),
        .error_arp_failed        (error_arp_failed),
        .error_arp_timeout       (error_arp_timeout),
        .busy                    (busy)
    );

    int total = 0;
    int bad   = 0;

    beat_t sent_q[$];
    beat_t fwd_q[$];

    // Packet knobs; k_outcome: 0 = ARP success, 1 = ARP error, 2 = no response.
    logic [31:0] k_ip;
    logic [47:0] k_mac;
    logic [7:0]  k_last_keep;
    bit          k_probe, k_toggle, k_inval, k_req_rdy;
    int          k_outcome, k_delay, k_beats, k_rst_after;

    int          o_req, o_hdr, o_mhdr, o_errf, o_errt, o_errt_q, o_lat;
    bit          o_errt_reqv, o_drop, o_skip, o_leak, o_busy_end, o_hung;
    logic [47:0] o_mac;

    task automatic idle_inputs();
        s_ip_hdr_valid = 0; s_ip_dest_ip = 0; s_tdata = 0; s_tkeep = 0; s_tvalid = 0;
        s_tlast = 0; s_tuser = 0; m_tready = 0; m_ip_hdr_ready = 0; arp_request_ready = 0;
        arp_response_valid = 0; arp_response_error = 0; arp_response_mac = 0;
        probe_only = 0; cache_invalidate = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 0;
    endtask

    task automatic knobs_default(input logic [31:0] ip);
        k_ip = ip; k_probe = 0; k_outcome = 0; k_delay = 3; k_mac = 48'h02AA_BBCC_DD00;
        k_beats = 3; k_last_keep = 8'hFF; k_toggle = 0; k_inval = 0; k_req_rdy = 1;
        k_rst_after = -1;
    endtask

    function automatic bit fwd_ok(input bit expect_fwd);
        if (!expect_fwd) return fwd_q.size() == 0;
        if (fwd_q.size() != sent_q.size()) return 0;
        foreach (sent_q[i]) if (fwd_q[i] !== sent_q[i]) return 0;
        return 1;
    endfunction

    // Acts as header source, ARP responder, payload source/sink and framer for one packet.
    task automatic run_packet();
        int qcount = 0;
        int beat   = 0;
        bit resp_sent = 0;
        bit hdr_hs;
        bit done = 0;
        sent_q.delete();
        fwd_q.delete();
        o_req = 0; o_hdr = 0; o_mhdr = 0; o_errf = 0; o_errt = 0; o_errt_q = -1; o_lat = -1;
        o_errt_reqv = 0; o_drop = 0; o_skip = 0; o_leak = 0; o_busy_end = 1; o_hung = 1;
        for (int b = 0; b < k_beats; b++) begin
            beat_t x;
            x[DW-1:0]     = {$urandom, $urandom};
            x[DW+KW-1:DW] = (b == k_beats - 1) ? k_last_keep : 8'hFF;
            x[DW+KW]      = (b == k_beats - 1);
            x[DW+KW+1]    = 1'($urandom_range(0, 1));
            sent_q.push_back(x);
        end
        s_ip_dest_ip   = k_ip;
        probe_only     = k_probe;
        s_ip_hdr_valid = 1;
        m_ip_hdr_ready = 1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (error_arp_timeout) begin
                o_errt++;
                o_errt_q    = qcount;
                o_errt_reqv = arp_request_valid;
            end
            if (error_arp_failed) o_errf++;
            if (drop_packet) o_drop = 1;
            if (skip_packet) o_skip = 1;
            if (m_ip_hdr_valid && o_lat < 0) o_lat = cyc;
            if (done) begin
                o_busy_end = busy;
                o_hung     = 0;
                break;
            end
            arp_request_ready  = k_req_rdy;
            arp_response_valid = (k_outcome != 2) && arp_response_ready && !resp_sent &&
                                 (qcount == k_delay);
            arp_response_error = (k_outcome == 1);
            arp_response_mac   = k_mac;
            cache_invalidate   = k_inval && arp_response_valid;
            rst                = (k_rst_after >= 0) && (beat == k_rst_after);
            s_tvalid           = (beat < k_beats) && !rst;
            {s_tuser, s_tlast, s_tkeep, s_tdata} = (beat < k_beats) ? sent_q[beat] : '0;
            m_tready           = k_toggle ? ((cyc % 2) == 1) : 1'b1;
            #1;
            hdr_hs = s_ip_hdr_valid && s_ip_hdr_ready;
            if (hdr_hs) o_hdr++;
            if (arp_request_valid && arp_request_ready) o_req++;
            if (arp_response_ready) qcount++;
            if (arp_response_valid && arp_response_ready) resp_sent = 1;
            if (m_ip_hdr_valid && m_ip_hdr_ready) o_mhdr++;
            if (m_tvalid && (drop_packet || skip_packet)) o_leak = 1;
            if (m_tvalid && m_tready) fwd_q.push_back({m_tuser, m_tlast, m_tkeep, m_tdata});
            if (s_tvalid && s_tready) begin
                if (s_tlast) done = 1;
                beat++;
            end
            if (rst) done = 1;
            @(posedge clk);
            #1;
            if (hdr_hs) s_ip_hdr_valid = 0;
        end
        o_mac = m_eth_dest_mac;
        idle_inputs();
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        s_tvalid = 1; m_tready = 1;
        #1;
        total++; if ({s_ip_hdr_ready, m_ip_hdr_valid, arp_request_valid, arp_response_ready} !== 4'b0) begin
            bad++; $display("FAIL reset_hdr: got %b want 0000",
                {s_ip_hdr_ready, m_ip_hdr_valid, arp_request_valid, arp_response_ready}); end
        total++; if ({drop_packet, skip_packet, error_arp_failed, error_arp_timeout} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000",
                {drop_packet, skip_packet, error_arp_failed, error_arp_timeout}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({s_tready, m_tvalid} !== 2'b00) begin
            bad++; $display("FAIL reset_payload: got %b want 00", {s_tready, m_tvalid}); end
        idle_inputs();
    endtask

    task automatic test_miss_hit();
        do_reset();
        knobs_default(32'h0A00_0005); k_delay = 5; k_mac = 48'h0200_0000_0001; k_beats = 4;
        run_packet();
        total++; if (o_hung !== 1'b0) begin bad++; $display("FAIL miss_done: hung=%b want 0", o_hung); end
        total++; if (o_req !== 1) begin bad++; $display("FAIL miss_req: got %0d want 1", o_req); end
        total++; if (o_mac !== 48'h0200_0000_0001) begin
            bad++; $display("FAIL miss_mac: got %h want 020000000001", o_mac); end
        total++; if (!fwd_ok(1)) begin
            bad++; $display("FAIL miss_fwd: got %0d beats want 4 matching", fwd_q.size()); end
        total++; if (o_busy_end !== 1'b0) begin bad++; $display("FAIL miss_idle: busy=%b want 0", o_busy_end); end
        knobs_default(32'h0A00_0005); k_mac = 48'h0BAD_0BAD_0BAD; k_beats = 4;
        run_packet();
        total++; if (o_req !== 0) begin bad++; $display("FAIL hit_req: got %0d want 0", o_req); end
        total++; if (o_lat !== 1) begin bad++; $display("FAIL hit_latency: got %0d want 1", o_lat); end
        total++; if (o_mac !== 48'h0200_0000_0001) begin
            bad++; $display("FAIL hit_mac: got %h want 020000000001", o_mac); end
        total++; if (!fwd_ok(1)) begin
            bad++; $display("FAIL hit_fwd: got %0d beats want 4 matching", fwd_q.size()); end
    endtask

    task automatic test_arp_error();
        do_reset();
        knobs_default(32'h0A00_0009); k_outcome = 1; k_beats = 3;
        run_packet();
        total++; if (o_errf !== 1) begin bad++; $display("FAIL err_pulse: got %0d want 1", o_errf); end
        total++; if (o_drop !== 1'b1) begin bad++; $display("FAIL err_drop: got %b want 1", o_drop); end
        total++; if (o_leak !== 1'b0 || !fwd_ok(0)) begin
            bad++; $display("FAIL err_leak: got %0d fwd beats want 0", fwd_q.size()); end
        total++; if (o_hung !== 1'b0 || o_busy_end !== 1'b0) begin
            bad++; $display("FAIL err_idle: hung=%b busy=%b want 0 0", o_hung, o_busy_end); end
    endtask

    task automatic test_timeout();
        do_reset();
        knobs_default(32'h0A00_000B); k_outcome = 2; k_req_rdy = 0; k_beats = 2;
        run_packet();
        total++; if (o_errt !== 1) begin bad++; $display("FAIL tmo_pulse: got %0d want 1", o_errt); end
        total++; if (o_errt_q !== TMO) begin
            bad++; $display("FAIL tmo_cycle: got %0d want %0d", o_errt_q, TMO); end
        total++; if (o_errt_reqv !== 1'b0) begin
            bad++; $display("FAIL tmo_reqv: got %b want 0", o_errt_reqv); end
        total++; if (o_drop !== 1'b1 || !fwd_ok(0) || o_busy_end !== 1'b0) begin
            bad++; $display("FAIL tmo_drop: drop=%b fwd=%0d busy=%b want 1 0 0",
                o_drop, fwd_q.size(), o_busy_end); end
        knobs_default(32'h0A00_000B); k_delay = TMO - 1; k_mac = 48'h02CC_0000_0016;
        run_packet();
        total++; if (o_errt !== 0 || o_mac !== 48'h02CC_0000_0016 || !fwd_ok(1)) begin
            bad++; $display("FAIL tmo_late_resp: errt=%0d mac=%h fwd=%0d want 0 02cc00000016 3",
                o_errt, o_mac, fwd_q.size()); end
    endtask

    task automatic test_probe();
        do_reset();
        knobs_default(32'h0A00_0014); k_probe = 1; k_mac = 48'h0200_0000_0014; k_beats = 3;
        run_packet();
        total++; if (o_skip !== 1'b1) begin bad++; $display("FAIL probe_skip: got %b want 1", o_skip); end
        total++; if (o_lat !== -1 || o_mhdr !== 0) begin
            bad++; $display("FAIL probe_mhdr: lat=%0d cnt=%0d want -1 0", o_lat, o_mhdr); end
        total++; if (!fwd_ok(0) || o_hung !== 1'b0) begin
            bad++; $display("FAIL probe_consume: fwd=%0d hung=%b want 0 0", fwd_q.size(), o_hung); end
        knobs_default(32'h0A00_0014);
        run_packet();
        total++; if (o_req !== 0 || o_mac !== 48'h0200_0000_0014) begin
            bad++; $display("FAIL probe_cached: req=%0d mac=%h want 0 020000000014", o_req, o_mac); end
    endtask

    task automatic test_backpressure_reset();
        do_reset();
        knobs_default(32'h0A00_0021); k_beats = 5; k_toggle = 1; k_last_keep = 8'h0F;
        run_packet();
        total++; if (!fwd_ok(1)) begin
            bad++; $display("FAIL bp_fwd: got %0d beats want 5 matching", fwd_q.size()); end
        total++; if (fwd_q.size() != 5 || fwd_q[4][DW+KW-1:DW] !== 8'h0F) begin
            bad++; $display("FAIL bp_last_keep: got %0d beats want last tkeep 0f", fwd_q.size()); end
        knobs_default(32'h0A00_0021); k_beats = 5; k_rst_after = 2;
        run_packet();
        total++; if (o_busy_end !== 1'b0 || o_hung !== 1'b0) begin
            bad++; $display("FAIL rst_busy: busy=%b hung=%b want 0 0", o_busy_end, o_hung); end
        total++; if (o_errf !== 0 || o_errt !== 0) begin
            bad++; $display("FAIL rst_noerr: errf=%0d errt=%0d want 0 0", o_errf, o_errt); end
        knobs_default(32'h0A00_0021);
        run_packet();
        total++; if (o_req !== 1) begin bad++; $display("FAIL rst_cache_cleared: req=%0d want 1", o_req); end
    endtask

    task automatic test_inval_collision();
        do_reset();
        knobs_default(32'h0A00_0030); k_inval = 1;
        run_packet();
        total++; if (!fwd_ok(1)) begin bad++; $display("FAIL inval_fwd: got %0d beats want 3", fwd_q.size()); end
        knobs_default(32'h0A00_0030);
        run_packet();
        total++; if (o_req !== 1) begin bad++; $display("FAIL inval_rerequest: req=%0d want 1", o_req); end
    endtask

    task automatic test_random();
        bit          mv   = 0;
        logic [31:0] mip  = 0;
        logic [47:0] mmac = 0;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            bit hit, e_fwd, e_drop, e_skip, e_chk_mac;
            int e_req, e_errf, e_errt, r;
            logic [47:0] e_mac;
            knobs_default(32'h0A00_0040 + 32'($urandom_range(0, 2)));
            k_probe     = ($urandom_range(0, 3) == 0);
            r           = int'($urandom_range(0, 9));
            k_outcome   = (r < 6) ? 0 : (r < 8) ? 1 : 2;
            k_delay     = int'($urandom_range(0, TMO - 1));
            k_beats     = int'($urandom_range(1, 5));
            k_toggle    = 1'($urandom_range(0, 1));
            k_inval     = ($urandom_range(0, 5) == 0);
            k_last_keep = 8'($urandom_range(1, 255));
            k_mac       = {16'h0200, $urandom};
            hit = mv && (mip == k_ip) && !k_probe;
            e_req = hit ? 0 : 1;
            e_fwd = 0; e_drop = 0; e_skip = 0; e_errf = 0; e_errt = 0; e_chk_mac = 1;
            e_mac = hit ? mmac : k_mac;
            if (hit) e_fwd = 1;
            else if (k_outcome == 0) begin
                e_fwd  = !k_probe;
                e_skip = k_probe;
                if (k_inval) mv = 0;
                else begin mv = 1; mip = k_ip; mmac = k_mac; end
            end else begin
                e_drop = 1; e_chk_mac = 0;
                if (k_outcome == 1) begin
                    e_errf = 1;
                    if (mip == k_ip) mv = 0;
                end else e_errt = 1;
            end
            run_packet();
            total++; if (o_hung !== 1'b0 || o_busy_end !== 1'b0 || o_hdr !== 1) begin
                bad++; $display("FAIL rnd%0d_flow: hung=%b busy=%b hdr=%0d want 0 0 1",
                    n, o_hung, o_busy_end, o_hdr); end
            total++; if (o_req !== e_req) begin
                bad++; $display("FAIL rnd%0d_req: got %0d want %0d", n, o_req, e_req); end
            total++; if (o_errf !== e_errf || o_errt !== e_errt) begin
                bad++; $display("FAIL rnd%0d_err: got %0d/%0d want %0d/%0d", n, o_errf, o_errt,
                    e_errf, e_errt); end
            total++; if (o_drop !== e_drop || o_skip !== e_skip || o_leak !== 1'b0) begin
                bad++; $display("FAIL rnd%0d_mode: drop=%b skip=%b leak=%b want %b %b 0",
                    n, o_drop, o_skip, o_leak, e_drop, e_skip); end
            total++; if (!fwd_ok(e_fwd) || o_mhdr !== int'(e_fwd)) begin
                bad++; $display("FAIL rnd%0d_fwd: beats=%0d mhdr=%0d want fwd=%b of %0d",
                    n, fwd_q.size(), o_mhdr, e_fwd, k_beats); end
            if (e_chk_mac) begin
                total++; if (o_mac !== e_mac) begin
                    bad++; $display("FAIL rnd%0d_mac: got %h want %h", n, o_mac, e_mac); end
            end
            if (e_errt == 1) begin
                total++; if (o_errt_q !== TMO) begin
                    bad++; $display("FAIL rnd%0d_tmo_cycle: got %0d want %0d", n, o_errt_q, TMO); end
            end
        end
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        test_reset();
        test_miss_hit();
        test_arp_error();
        test_timeout();
        test_probe();
        test_backpressure_reset();
        test_inval_collision();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
